// File: rtl/alarm_seq_pkg.sv
// Shared types and helpers for the alarm sequencer: FSM state encoding and
// the width of the seconds counter.
package alarm_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } alarm_state_t;

  // Wide enough to count 0..max(ring_sec, snooze_sec)-1 without wrapping.
  function automatic int sec_cnt_width(input int ring_sec, input int snooze_sec);
    int m;
    m = (ring_sec > snooze_sec) ? ring_sec : snooze_sec;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alarm_half_div.sv
// Half-period divider: div_cnt runs 0..HALF_MS-1 while enabled and toggles
// phase on every wrap. A synchronous clear restarts it at div_cnt=0, phase=1.
module alarm_half_div #(
  parameter int HALF_MS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic phase_next
);

  localparam int DIV_W = (HALF_MS > 1) ? $clog2(HALF_MS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_MS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             phase_q, phase_d;

  // Next divider count and phase; clear has priority over counting.
  always_comb begin
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    if (clr) begin
      div_cnt_d = {DIV_W{1'b0}};
      phase_d   = 1'b1;
    end else if (en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = {DIV_W{1'b0}};
        phase_d   = ~phase_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= {DIV_W{1'b0}};
      phase_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Next-cycle phase lets the parent register its outputs in step with state.
  assign phase_next = phase_d;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm control FSM: ring, snooze, stop, timeout and re-trigger lockout.
// Define ALARM_PATTERN_EN to gate ring with the half-period beep pattern.
module alarm_sequencer
  import alarm_seq_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int HALF_MS    = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1s,
  input  logic               alarm_en,
  input  logic               time_match,
  input  logic               stop_req,
  input  logic               snooze_req,
  output logic               ring,
  output logic               led_alarm,
  output logic [1:0]         snooze_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int               SEC_W       = sec_cnt_width(RING_SEC, SNOOZE_SEC);
  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]       MAX_SNZ     = 2'(MAX_SNOOZE);
  // A half period longer than one second would make no sense; clamp to CLK_HZ.
  localparam int               HALF_CYC    = (HALF_MS < CLK_HZ) ? HALF_MS : CLK_HZ;

  alarm_state_t     state_q, state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             ring_q, ring_d;
  logic             led_q, led_d;
  logic             div_clr, div_en, phase_next;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sec_cnt_q    <= {SEC_W{1'b0}};
      snooze_cnt_q <= 2'd0;
      ring_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_q       <= ring_d;
      led_q        <= led_d;
    end
  end

  // Next state; disarming overrides everything, requests beat the timeout tick.
  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!alarm_en) begin
      state_d      = IDLE;
      sec_cnt_d    = {SEC_W{1'b0}};
      snooze_cnt_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (time_match) begin
            state_d   = RINGING;
            sec_cnt_d = {SEC_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        RINGING: begin
          if (stop_req) begin
            state_d      = LOCKOUT;
            sec_cnt_d    = {SEC_W{1'b0}};
            snooze_cnt_d = 2'd0;
          end else if (snooze_req && (snooze_cnt_q < MAX_SNZ)) begin
            state_d      = SNOOZE;
            sec_cnt_d    = {SEC_W{1'b0}};
            snooze_cnt_d = snooze_cnt_q + 2'd1;
          end else if (tick_1s) begin
            if (sec_cnt_q == RING_LAST) begin
              state_d      = LOCKOUT;
              sec_cnt_d    = {SEC_W{1'b0}};
              snooze_cnt_d = 2'd0;
            end else begin
              sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
          end else begin
            state_d = RINGING;
          end
        end
        SNOOZE: begin
          if (stop_req) begin
            state_d      = LOCKOUT;
            sec_cnt_d    = {SEC_W{1'b0}};
            snooze_cnt_d = 2'd0;
          end else if (tick_1s) begin
            if (sec_cnt_q == SNOOZE_LAST) begin
              state_d   = RINGING;
              sec_cnt_d = {SEC_W{1'b0}};
            end else begin
              sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
          end else begin
            state_d = SNOOZE;
          end
        end
        LOCKOUT: begin
          if (!time_match) begin
            state_d   = IDLE;
            sec_cnt_d = {SEC_W{1'b0}};
          end else begin
            state_d = LOCKOUT;
          end
        end
        default: begin
          state_d      = IDLE;
          sec_cnt_d    = {SEC_W{1'b0}};
          snooze_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Divider restarts on entry to RINGING/SNOOZE and only runs inside them.
  always_comb begin
    div_clr = (state_d != state_q) && ((state_d == RINGING) || (state_d == SNOOZE));
    div_en  = (state_q == RINGING) || (state_q == SNOOZE);
  end

  alarm_half_div #(
    .HALF_MS (HALF_CYC)
  ) u_half_div (
    .clk        (clk),
    .reset      (reset),
    .clr        (div_clr),
    .en         (div_en),
    .phase_next (phase_next)
  );

  // Output decode from next state, so the output flops track the state flops.
  always_comb begin
`ifdef ALARM_PATTERN_EN
    ring_d = (state_d == RINGING) && phase_next;
`else
    ring_d = (state_d == RINGING);
`endif
    case (state_d)
      RINGING: led_d = 1'b1;
      SNOOZE:  led_d = phase_next;
      default: led_d = alarm_en;
    endcase
  end

  assign ring       = ring_q;
  assign led_alarm  = led_q;
  assign snooze_cnt = snooze_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_SEC=5, SNOOZE_SEC=3,
// MAX_SNOOZE=2, HALF_MS=4; ring pattern checks follow ALARM_PATTERN_EN.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1s, alarm_en, time_match, stop_req, snooze_req;
  logic       ring, led_alarm;
  logic [1:0] snooze_cnt;
  logic [1:0] state;

  int chk_cnt = 0;
  int err_cnt = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2, S_LOCK = 2'd3;

  alarm_sequencer #(
    .CLK_HZ     (1000),
    .RING_SEC   (5),
    .SNOOZE_SEC (3),
    .MAX_SNOOZE (2),
    .HALF_MS    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1s    (tick_1s),
    .alarm_en   (alarm_en),
    .time_match (time_match),
    .stop_req   (stop_req),
    .snooze_req (snooze_req),
    .ring       (ring),
    .led_alarm  (led_alarm),
    .snooze_cnt (snooze_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; inputs and samples sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_req = 1'b1; step(); snooze_req = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1; step(); stop_req = 1'b0;
  endtask

  task automatic trigger();
    time_match = 1'b1; step(); time_match = 1'b0;
  endtask

  logic exp_bit;

  initial begin
    reset = 1'b0; tick_1s = 1'b0; alarm_en = 1'b0; time_match = 1'b0;
    stop_req = 1'b0; snooze_req = 1'b0;
    #12;
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    check_eq("rst_ring", 32'(ring), 32'd0);
    check_eq("rst_led", 32'(led_alarm), 32'd0);
    check_eq("rst_snz", 32'(snooze_cnt), 32'd0);
    reset = 1'b1;
    step();

    // 1: trigger, ring pattern, timeout, lockout release
    alarm_en = 1'b1; step();
    check_eq("armed_led", 32'(led_alarm), 32'd1);
    check_eq("armed_state", 32'(state), 32'(S_IDLE));
    time_match = 1'b1; step();
    check_eq("t1_state", 32'(state), 32'(S_RING));
    check_eq("t1_ring", 32'(ring), 32'd1);
    for (int i = 1; i < 12; i++) begin
      step();
`ifdef ALARM_PATTERN_EN
      exp_bit = ((i / 4) % 2) == 0;
`else
      exp_bit = 1'b1;
`endif
      check_eq($sformatf("t1_ring_pat%0d", i), 32'(ring), 32'(exp_bit));
      check_eq($sformatf("t1_led%0d", i), 32'(led_alarm), 32'd1);
    end
    time_match = 1'b0;
    for (int i = 0; i < 4; i++) pulse_tick();
    check_eq("t1_ring_4ticks", 32'(state), 32'(S_RING));
    pulse_tick();
    check_eq("t1_timeout_state", 32'(state), 32'(S_LOCK));
    check_eq("t1_timeout_ring", 32'(ring), 32'd0);
    step();
    check_eq("t1_idle", 32'(state), 32'(S_IDLE));
    check_eq("t1_snz", 32'(snooze_cnt), 32'd0);

    // 2: lockout holds while time_match persists across a stop
    time_match = 1'b1; step();
    check_eq("t2_ring", 32'(state), 32'(S_RING));
    pulse_stop();
    check_eq("t2_stop_state", 32'(state), 32'(S_LOCK));
    check_eq("t2_stop_ring", 32'(ring), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t2_hold%0d", i), 32'(state), 32'(S_LOCK));
      check_eq($sformatf("t2_hold_ring%0d", i), 32'(ring), 32'd0);
    end
    time_match = 1'b0; step();
    check_eq("t2_release", 32'(state), 32'(S_IDLE));
    step();
    check_eq("t2_no_retrig", 32'(ring), 32'd0);

    // 3: snooze limit and LED blink in snooze
    trigger();
    check_eq("t3_ring", 32'(state), 32'(S_RING));
    pulse_snooze();
    check_eq("t3_snz1_state", 32'(state), 32'(S_SNZ));
    check_eq("t3_snz1_cnt", 32'(snooze_cnt), 32'd1);
    check_eq("t3_snz1_ring", 32'(ring), 32'd0);
    check_eq("t3_blink0", 32'(led_alarm), 32'd1);
    for (int i = 1; i < 12; i++) begin
      step();
      exp_bit = ((i / 4) % 2) == 0;
      check_eq($sformatf("t3_blink%0d", i), 32'(led_alarm), 32'(exp_bit));
    end
    pulse_snooze();
    check_eq("t3_snz_ignored", 32'(snooze_cnt), 32'd1);
    pulse_tick(); pulse_tick();
    check_eq("t3_snz_2ticks", 32'(state), 32'(S_SNZ));
    pulse_tick();
    check_eq("t3_back_ring", 32'(state), 32'(S_RING));
    check_eq("t3_back_ring_cnt", 32'(snooze_cnt), 32'd1);
    pulse_snooze();
    check_eq("t3_snz2_state", 32'(state), 32'(S_SNZ));
    check_eq("t3_snz2_cnt", 32'(snooze_cnt), 32'd2);
    for (int i = 0; i < 3; i++) pulse_tick();
    check_eq("t3_back_ring2", 32'(state), 32'(S_RING));
    pulse_snooze();
    check_eq("t3_snz3_state", 32'(state), 32'(S_RING));
    check_eq("t3_snz3_cnt", 32'(snooze_cnt), 32'd2);
    for (int i = 0; i < 4; i++) pulse_tick();
    check_eq("t3_ring_4ticks", 32'(state), 32'(S_RING));
    pulse_tick();
    check_eq("t3_timeout", 32'(state), 32'(S_LOCK));
    check_eq("t3_timeout_cnt", 32'(snooze_cnt), 32'd0);
    step();
    check_eq("t3_idle", 32'(state), 32'(S_IDLE));

    // 4: disarm while snoozing
    trigger();
    pulse_snooze();
    check_eq("t4_snz", 32'(snooze_cnt), 32'd1);
    alarm_en = 1'b0; step();
    check_eq("t4_state", 32'(state), 32'(S_IDLE));
    check_eq("t4_cnt", 32'(snooze_cnt), 32'd0);
    check_eq("t4_ring", 32'(ring), 32'd0);
    check_eq("t4_led", 32'(led_alarm), 32'd0);
    alarm_en = 1'b1; step();

    // 5: request collides with the timeout tick
    trigger();
    for (int i = 0; i < 4; i++) pulse_tick();
    tick_1s = 1'b1; stop_req = 1'b1; step(); tick_1s = 1'b0; stop_req = 1'b0;
    check_eq("t5_stop_state", 32'(state), 32'(S_LOCK));
    check_eq("t5_stop_cnt", 32'(snooze_cnt), 32'd0);
    step();
    trigger();
    for (int i = 0; i < 4; i++) pulse_tick();
    tick_1s = 1'b1; snooze_req = 1'b1; step(); tick_1s = 1'b0; snooze_req = 1'b0;
    check_eq("t5_snz_state", 32'(state), 32'(S_SNZ));
    check_eq("t5_snz_cnt", 32'(snooze_cnt), 32'd1);
    pulse_stop();
    check_eq("t5_snz_stop", 32'(state), 32'(S_LOCK));
    check_eq("t5_snz_stop_cnt", 32'(snooze_cnt), 32'd0);
    step();

    // 6: asynchronous reset while ringing
    trigger();
    check_eq("t6_ring", 32'(ring), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_async_ring", 32'(ring), 32'd0);
    check_eq("t6_async_state", 32'(state), 32'(S_IDLE));
    #3 reset = 1'b1;
    step();
    check_eq("t6_post_state", 32'(state), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controls the alarm for the 1 kHz MIN:SEC alarm clock.
- Decides when the alarm sound generator is enabled and handles stop, snooze and ring timeout.
- Prevents the alarm from re-triggering while the current time still matches the alarm time.
- Sits between the timekeeping/compare logic and the piezo sound block; also drives the alarm indicator LED.

Parameters:
- CLK_HZ, 1000: system clock frequency; sets divider lengths.
- RING_SEC, 60: seconds the alarm rings before it stops automatically (≥2).
- SNOOZE_SEC, 300: seconds spent in snooze before ringing again (≥2).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..3).
- HALF_MS, 500: half period, in clk cycles, of the LED blink and the ring pattern.

Ports:
- clk  in  1  system clock (1 kHz)
- reset  in  1  asynchronous, active-low reset
- tick_1s  in  1  one-cycle pulse, once per second, from the timekeeping counter
- alarm_en  in  1  level; alarm armed
- time_match  in  1  level; current MIN:SEC equals alarm MIN:SEC
- stop_req  in  1  one-cycle pulse from key logic
- snooze_req  in  1  one-cycle pulse from key logic
- ring  out  1  enable to the sound generator
- led_alarm  out  1  alarm indicator LED
- snooze_cnt  out  2  snoozes used in the current alarm event
- state  out  2  current FSM state (debug)

Behaviour:
- Reset (asynchronous, active-low) clears all registers:
  - state=IDLE; sec_cnt=0; snooze_cnt=0; div_cnt=0; phase=1; ring=0; led_alarm=0.
- States: IDLE=0, RINGING=1, SNOOZE=2, LOCKOUT=3. All state and counters are registered on the clk rising edge.
- Global rule: alarm_en=0 in any state → IDLE next cycle, with sec_cnt=0 and snooze_cnt=0. This has the highest priority.
- IDLE:
  - alarm_en && time_match → RINGING; sec_cnt=0.
- RINGING (priority order):
  1. stop_req → LOCKOUT; snooze_cnt=0.
  2. snooze_req && snooze_cnt<MAX_SNOOZE → SNOOZE; sec_cnt=0; snooze_cnt+1.
  3. snooze_req with snooze_cnt==MAX_SNOOZE is ignored; the alarm keeps ringing.
  4. tick_1s: if sec_cnt==RING_SEC-1 → LOCKOUT and snooze_cnt=0; else sec_cnt+1.
  - If stop_req or snooze_req arrives in the same cycle as the timeout tick, the request wins.
- SNOOZE:
  - stop_req → LOCKOUT; snooze_cnt=0.
  - tick_1s: if sec_cnt==SNOOZE_SEC-1 → RINGING and sec_cnt=0; else sec_cnt+1.
  - snooze_req is ignored.
- LOCKOUT:
  - time_match==0 → IDLE. No re-trigger while the match second persists.
- Counter widths:
  - sec_cnt width = $clog2(max(RING_SEC, SNOOZE_SEC)).
  - The sec_cnt counter never wraps; it is cleared on every state entry.
- Divider:
  - div_cnt counts 0..HALF_MS-1 and toggles phase on wrap.
  - It runs only in RINGING or SNOOZE.
  - div_cnt=0 and phase=1 on entry to either state.
- Outputs are Moore-decoded from registered state (registered, no combinational path from inputs):
  - ring = (state==RINGING), subject to the optional feature below.
  - led_alarm: RINGING → 1; SNOOZE → phase (blink); IDLE/LOCKOUT → alarm_en (registered).
- Latency: ring asserts on the first edge after alarm_en && time_match is sampled in IDLE, and deasserts on the first edge after stop_req.

Optional Feature:
- Macro: ALARM_PATTERN_EN.
- Defined: ring = (state==RINGING) && phase, giving a HALF_MS on / HALF_MS off beep that starts with an on half.
- Undefined: ring = (state==RINGING), a continuous tone. The divider is still used for the LED blink.

Decomposition:
- Package alarm_seq_pkg holds:
  - the state enum type alarm_state_t (IDLE, RINGING, SNOOZE, LOCKOUT);
  - the 2-bit STATE_W constant;
  - the function computing the sec_cnt width.
- One sub-module, alarm_half_div: the HALF_MS divider with sync clear and enable, outputting phase.

Test Plan:
Use RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, HALF_MS=4 unless stated.
1. Trigger and timeout: alarm_en=1; raise time_match for 1 s, then drop it.
   - ring=1 on the next edge.
   - After 5 tick_1s pulses: state=LOCKOUT, then IDLE once time_match=0; ring=0; snooze_cnt=0.
2. Lockout: time_match held high across a stop_req.
   - State stays LOCKOUT and ring=0 until time_match falls.
   - No second ring.
3. Snooze limit: three snooze_req pulses, each issued during a RINGING period.
   - First two: SNOOZE for 3 ticks, then RINGING; snooze_cnt=1, then 2.
   - Third is ignored: stays RINGING with snooze_cnt=2, times out after 5 ticks.
4. Disarm mid-event: in SNOOZE with snooze_cnt=1, drop alarm_en.
   - Next edge: IDLE, snooze_cnt=0, ring=0, led_alarm=0.
5. Collision: stop_req in the same cycle as the 5th tick_1s in RINGING.
   - Result: LOCKOUT with snooze_cnt=0.
   - The same collision with snooze_req gives SNOOZE with snooze_cnt=1.
6. Pattern and reset:
   - With ALARM_PATTERN_EN, ring toggles 1111 0000 1111 in clk cycles during RINGING; led_alarm blinks with period 8 in SNOOZE.
   - Asserting reset mid-RINGING forces ring=0 and state=IDLE immediately, without waiting for an edge.
